// File: rtl/pc_epc_unit_pkg.sv
// Shared CPU definitions: branch encodings, exception causes, PC/EPC FSM states.
// Imported by the PC/EPC unit, its branch evaluator and the bus interface.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BLE = 2'b10,
    BR_BGT = 2'b11
  } branch_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIVZERO  = 2'b11
  } exc_cause_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_VEC_BASE = 32'h0000_00FD;

  // Invalid opcode outranks overflow, which outranks divide-by-zero.
  function automatic exc_cause_e pick_cause(input logic [2:0] req);
    exc_cause_e c;
    if (req[0])      c = CAUSE_OPCODE;
    else if (req[1]) c = CAUSE_OVERFLOW;
    else if (req[2]) c = CAUSE_DIVZERO;
    else             c = CAUSE_NONE;
    return c;
  endfunction

endpackage

// File: rtl/pc_epc_unit_if.sv
// Signal bundle around the PC/EPC unit; the controller side drives requests,
// the unit side returns PC, EPC and exception status.
interface pc_epc_if (input logic clk);
  logic [31:0] pc_in;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic        alu_gt;
  logic [2:0]  exc_req;
  logic        exc_ack;
  logic [31:0] pc_out;
  logic [31:0] epc_out;
  logic        exc_pending;
  logic [1:0]  exc_cause;
  logic [31:0] exc_vector;
  logic        pc_misaligned;

  // No valid/ready pairs here: every request is a single-cycle level sampled on
  // the rising clk edge; outputs are register values valid the cycle after.
  modport master (
    input  clk, pc_out, epc_out, exc_pending, exc_cause, exc_vector, pc_misaligned,
    output pc_in, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt, exc_req, exc_ack
  );

  modport slave (
    input  clk, pc_in, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt, exc_req, exc_ack,
    output pc_out, epc_out, exc_pending, exc_cause, exc_vector, pc_misaligned
  );
endinterface

// File: rtl/pc_epc_unit_branch_cond.sv
// Combinational branch resolution from the ALU comparison flags.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [1:0] branch_op,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (branch_op_e'(branch_op))
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLE:  taken = !alu_gt;
      BR_BGT:  taken = alu_gt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_epc_unit.sv
// Program counter with exception PC capture: loads PC on write/taken branch,
// and on an exception request saves PC-4 and the cause until acknowledged.
module pc_epc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE = DEFAULT_VEC_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic [2:0]  exc_req,
  input  logic        exc_ack,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        exc_pending,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_vector,
  output logic        pc_misaligned
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  exc_cause_e  cause_q, cause_d;
  logic        mis_q, mis_d;
  logic        taken;
  logic        pc_en;

  branch_cond u_branch_cond (
    .branch_op (branch_op),
    .alu_zero  (alu_zero),
    .alu_gt    (alu_gt),
    .taken     (taken)
  );

  assign pc_en = pc_write | (pc_write_cond & taken);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_RUN: begin
        // An exception wins over any PC load in the same cycle.
        if (exc_req != 3'b000) begin
          epc_d   = pc_q - 32'd4;
          cause_d = pick_cause(exc_req);
          state_d = ST_EXC;
        end else if (pc_en) begin
          pc_d = pc_in;
        end
      end
      ST_EXC: begin
        if (pc_write) pc_d = pc_in;
        if (exc_ack) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
    mis_d = (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0;
      cause_q <= CAUSE_NONE;
      mis_q   <= (RESET_PC[1:0] != 2'b00);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out        = pc_q;
  assign epc_out       = epc_q;
  assign exc_pending   = (state_q == ST_EXC);
  assign exc_cause     = cause_q;
  assign pc_misaligned = mis_q;
  assign exc_vector    = (cause_q != CAUSE_NONE)
                         ? (VEC_BASE + {30'h0, cause_q} - 32'd1) : 32'h0;

endmodule

// File: tb/tb_pc_epc_unit.sv
// Bench for pc_epc_unit: directed vector table followed by random traffic
// compared against a behavioural model.
module tb_pc_epc_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pc_epc_if bus (.clk(clk));

  pc_epc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (bus.pc_in),
    .pc_write      (bus.pc_write),
    .pc_write_cond (bus.pc_write_cond),
    .branch_op     (bus.branch_op),
    .alu_zero      (bus.alu_zero),
    .alu_gt        (bus.alu_gt),
    .exc_req       (bus.exc_req),
    .exc_ack       (bus.exc_ack),
    .pc_out        (bus.pc_out),
    .epc_out       (bus.epc_out),
    .exc_pending   (bus.exc_pending),
    .exc_cause     (bus.exc_cause),
    .exc_vector    (bus.exc_vector),
    .pc_misaligned (bus.pc_misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc_in;
    logic        wr;
    logic        wc;
    logic [1:0]  op;
    logic        z;
    logic        g;
    logic [2:0]  req;
    logic        ack;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic [1:0]  e_cause;
    logic        e_pend;
    logic [31:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  // behavioural model state
  bit          m_in_exc;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  int          m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc_in, input logic wr, input logic wc,
                       input logic [1:0] op, input logic z, input logic g,
                       input logic [2:0] req, input logic ack);
    reset             = rst;
    bus.pc_in         = pc_in;
    bus.pc_write      = wr;
    bus.pc_write_cond = wc;
    bus.branch_op     = op;
    bus.alu_zero      = z;
    bus.alu_gt        = g;
    bus.exc_req       = req;
    bus.exc_ack       = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                           input logic [1:0] cause, input logic pend, input logic [31:0] vec);
    check({tag, " pc_out"},        bus.pc_out,        pc);
    check({tag, " epc_out"},       bus.epc_out,       epc);
    check({tag, " exc_cause"},     {30'h0, bus.exc_cause},   {30'h0, cause});
    check({tag, " exc_pending"},   {31'h0, bus.exc_pending}, {31'h0, pend});
    check({tag, " exc_vector"},    bus.exc_vector,    vec);
    check({tag, " pc_misaligned"}, {31'h0, bus.pc_misaligned}, {31'h0, (pc[1:0] != 2'b00)});
  endtask

  function automatic vec_t mk(input logic rst, input logic [31:0] pc_in, input logic wr,
                              input logic wc, input logic [1:0] op, input logic z, input logic g,
                              input logic [2:0] req, input logic ack, input logic [31:0] e_pc,
                              input logic [31:0] e_epc, input logic [1:0] e_cause,
                              input logic e_pend, input logic [31:0] e_vec);
    vec_t v;
    v.rst = rst; v.pc_in = pc_in; v.wr = wr; v.wc = wc; v.op = op; v.z = z; v.g = g;
    v.req = req; v.ack = ack; v.e_pc = e_pc; v.e_epc = e_epc; v.e_cause = e_cause;
    v.e_pend = e_pend; v.e_vec = e_vec;
    return v;
  endfunction

  // Reference: the spec's rules applied to whole-register values.
  task automatic model_step(input logic rst, input logic [31:0] pc_in, input logic wr,
                            input logic wc, input logic [1:0] op, input logic z, input logic g,
                            input logic [2:0] req, input logic ack);
    bit take;
    take = (op == 2'd0) ? z : (op == 2'd1) ? !z : (op == 2'd2) ? !g : g;
    if (rst) begin
      m_in_exc = 0; m_pc = 32'h0; m_epc = 32'h0; m_cause = 0;
    end else if (!m_in_exc) begin
      if (req != 0) begin
        m_epc = m_pc - 32'd4;
        m_cause = 0;
        for (int b = 2; b >= 0; b--) if (req[b]) m_cause = b + 1;
        m_in_exc = 1;
      end else if (wr || (wc && take)) begin
        m_pc = pc_in;
      end
    end else begin
      if (wr) m_pc = pc_in;
      if (ack) begin
        m_in_exc = 0;
        m_cause = 0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //        rst pc_in        wr wc op    z  g  req     ack  e_pc          e_epc         cz  pd vec
    tbl.push_back(mk(1, 32'h0,  0, 0, 2'd0, 0, 0, 3'b000, 0, 32'h0,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h4,  1, 0, 2'd0, 0, 0, 3'b000, 0, 32'h4,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 1, 2'd1, 1, 0, 3'b000, 0, 32'h4,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 1, 2'd1, 0, 0, 3'b000, 0, 32'h40,       32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h20, 1, 0, 2'd0, 0, 0, 3'b000, 0, 32'h20,       32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h99, 1, 0, 2'd0, 0, 0, 3'b110, 0, 32'h20,       32'h1C,       2'd2, 1, 32'hFE));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b001, 0, 32'h20,       32'h1C,       2'd2, 1, 32'hFE));
    tbl.push_back(mk(0, 32'h50, 0, 1, 2'd0, 1, 0, 3'b000, 0, 32'h20,       32'h1C,       2'd2, 1, 32'hFE));
    tbl.push_back(mk(0, 32'h80, 1, 0, 2'd0, 0, 0, 3'b000, 1, 32'h80,       32'h1C,       2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b000, 1, 32'h80,       32'h1C,       2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  1, 0, 2'd0, 0, 0, 3'b000, 0, 32'h0,        32'h1C,       2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b001, 0, 32'h0,        32'hFFFFFFFC, 2'd1, 1, 32'hFD));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b000, 1, 32'h0,        32'hFFFFFFFC, 2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b100, 0, 32'h0,        32'hFFFFFFFC, 2'd3, 1, 32'hFF));
    tbl.push_back(mk(1, 32'h0,  0, 0, 2'd0, 0, 0, 3'b100, 0, 32'h0,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h6,  1, 0, 2'd0, 0, 0, 3'b000, 0, 32'h6,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h8,  0, 1, 2'd2, 0, 0, 3'b000, 0, 32'h8,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'hC,  0, 1, 2'd3, 0, 0, 3'b000, 0, 32'h8,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'hC,  0, 1, 2'd3, 0, 1, 3'b000, 0, 32'hC,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10, 0, 1, 2'd2, 0, 1, 3'b000, 0, 32'hC,        32'h0,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b011, 0, 32'hC,        32'h8,        2'd1, 1, 32'hFD));
    tbl.push_back(mk(0, 32'h0,  0, 1, 2'd0, 1, 0, 3'b000, 0, 32'hC,        32'h8,        2'd1, 1, 32'hFD));
    tbl.push_back(mk(0, 32'h0,  0, 0, 2'd0, 0, 0, 3'b000, 1, 32'hC,        32'h8,        2'd0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h14, 0, 1, 2'd0, 1, 0, 3'b000, 0, 32'h14,       32'h8,        2'd0, 0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].pc_in, tbl[i].wr, tbl[i].wc, tbl[i].op, tbl[i].z, tbl[i].g,
            tbl[i].req, tbl[i].ack);
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_cause,
                tbl[i].e_pend, tbl[i].e_vec);
    end

    // Hand-written: reset held for several cycles while an exception is pending.
    drive(0, 32'h30, 0, 0, 2'd0, 0, 0, 3'b010, 0);
    check_all("seq_exc_enter", 32'h14, 32'h10, 2'd2, 1, 32'hFE);
    drive(1, 32'h44, 1, 0, 2'd0, 0, 0, 3'b111, 1);
    drive(1, 32'h44, 1, 1, 2'd1, 0, 0, 3'b111, 0);
    check_all("seq_reset_hold", 32'h0, 32'h0, 2'd0, 0, 32'h0);

    // Random traffic against the model.
    m_in_exc = 0; m_pc = 0; m_epc = 0; m_cause = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_wr, r_wc, r_z, r_g, r_ack;
      logic [31:0] r_pc;
      logic [1:0]  r_op;
      logic [2:0]  r_req;
      r_rst = ($urandom_range(0, 59) == 0);
      r_pc  = $urandom;
      r_wr  = ($urandom_range(0, 3) == 0);
      r_wc  = ($urandom_range(0, 2) == 0);
      r_op  = 2'($urandom_range(0, 3));
      r_z   = 1'($urandom_range(0, 1));
      r_g   = 1'($urandom_range(0, 1));
      r_req = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      r_ack = ($urandom_range(0, 3) == 0);
      drive(r_rst, r_pc, r_wr, r_wc, r_op, r_z, r_g, r_req, r_ack);
      model_step(r_rst, r_pc, r_wr, r_wc, r_op, r_z, r_g, r_req, r_ack);
      check_all("rand", m_pc, m_epc, 2'(m_cause), m_in_exc,
                (m_cause != 0) ? 32'hFD + 32'(m_cause) - 32'd1 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
